mux_n_rr: RTL and testbench

//   N-channel, WIDTH-bit multiplexer; generalises the 2:1 mux. Each channel has a

---
 rtl/mux_n_rr.sv | 169 ++++++++++++++++
 tb/tb_mux_n_rr.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_rr.sv
// mux_n_rr: N-channel, WIDTH-bit multiplexer. Each channel has a valid/ready
// handshake, and one registered output stage feeds the consumer. The channel
// is picked either by the sel port (mode=0) or by round-robin among the valid
// channels (mode=1).
//
// Optional feature: define MUX_LOCK_EN to add packet locking. This adds the
// in_last port. The grant then stays on one channel from its first beat until
// a beat with in_last=1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   mode       0 = manual select (sel), 1 = round-robin
//   sel        manual channel index; values >= N grant nothing
//   in_data    channel i data in bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   in_last    (MUX_LOCK_EN only) per-channel end-of-packet marker
//   out_data   registered output data
//   out_chan   index of the channel that supplied out_data
//   out_valid  output valid
//   out_ready  consumer ready
module mux_n_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [$clog2(N)-1:0]     sel,
  input  logic [N*WIDTH-1:0]       in_data,
  input  logic [N-1:0]             in_valid,
  output logic [N-1:0]             in_ready,
`ifdef MUX_LOCK_EN
  input  logic [N-1:0]             in_last,
`endif
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N)-1:0]     out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned SEL_W = $clog2(N);
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  // State registers
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_LOCK_EN
  logic             lock_q, lock_d;
`endif

  // Combinational arbitration signals
  logic             pipe_ready;
  logic             sel_ok;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;
  logic [N-1:0]     in_ready_c;

  // The output stage can accept a beat when it is empty or is draining this cycle
  assign pipe_ready = !out_valid_q || out_ready;
  assign sel_ok     = ({1'b0, sel} < N_EXT);

  // Grant selection: manual index, or the first valid channel after rr_ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_found    = 1'b0;
    rr_idx      = '0;
    if (!mode) begin
      grant_valid = sel_ok;
      grant_idx   = sel;
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        rr_idx = SEL_W'((32'(rr_ptr_q) + k) % N);
        if (!rr_found && in_valid[rr_idx]) begin
          rr_found  = 1'b1;
          grant_idx = rr_idx;
        end
      end
      grant_valid = rr_found;
    end
`ifdef MUX_LOCK_EN
    // rr_ptr_q holds the channel of the last transfer, so it is the channel
    // that owns the lock
    if (lock_q) begin
      grant_valid = 1'b1;
      grant_idx   = rr_ptr_q;
    end
`endif
  end

  // Data of the granted channel
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-channel ready, one-hot or zero
  always_comb begin
    in_ready_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready_c[i] = grant_valid && (grant_idx == SEL_W'(i)) && pipe_ready && rst_n;
    end
  end

  assign transfer = grant_valid && in_valid[grant_idx] && pipe_ready && rst_n;

  // Next-state logic for the output register, rr pointer and lock
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_LOCK_EN
    lock_d      = lock_q;
`endif
    if (transfer) begin
      // A load replaces any beat that drains in the same cycle, so there is no bubble
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      rr_ptr_d    = grant_idx;
`ifdef MUX_LOCK_EN
      lock_d      = !in_last[grant_idx];
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; rr_ptr starts at N-1 so channel 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= LAST_CH;
`ifdef MUX_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_rr.sv
// Testbench for mux_n_rr: directed scenarios followed by randomized traffic,
// all checked against a cycle-level reference model of the mux.
module tb_mux_n_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic [2:0]     in_last3;
`endif

  // Second instance with N=3 for the out-of-range sel case
  logic [1:0]     sel3;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_chan3;
  logic           out_valid3;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic           m_valid;
  logic [W-1:0]   m_data;
  int             m_chan;
  int             m_ptr;
  logic           m_lock;

  mux_n_rr #(.N(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_LOCK_EN
    .in_last(in_last),
`endif
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_n_rr #(.N(3), .WIDTH(W)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef MUX_LOCK_EN
    .in_last(in_last3),
`endif
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel the mux should grant this cycle, or -1 for none
  function automatic int model_grant();
    if (m_lock) return m_ptr;
    if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: check ready before the edge, advance the model, check outputs after it
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           g;
    logic         room;
    room    = !m_valid || out_ready;
    g       = model_grant();
    exp_rdy = '0;
    if (rst_n && room && g >= 0) exp_rdy[g] = 1'b1;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = N - 1; m_lock = 1'b0;
    end else if (g >= 0 && exp_rdy[g] && in_valid[g]) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_chan  = g;
      m_ptr   = g;
`ifdef MUX_LOCK_EN
      m_lock  = !in_last[g];
`endif
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_chan", 32'(out_chan), 32'(m_chan));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq3 [5] = '{0, 1, 2, 3, 0};
    int exp_seq4 [7] = '{1, 3, 1, 3, 1, 1, 1};
    logic [W-1:0] held;

    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = N - 1; m_lock = 1'b0;
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = 4'b1111;
    out_ready = 1'b1;
    sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211;
`ifdef MUX_LOCK_EN
    in_last = '1; in_last3 = '1;
`endif

    // Reset with all channels valid
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    // Manual select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h11A52233;
    #1;
    check("man_in_ready", 32'(in_ready), 32'h4);
    step();
    check("man_out_data", 32'(out_data), 32'hA5);
    check("man_out_chan", 32'(out_chan), 32'h2);

    // Round-robin across all channels at full throughput
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_all_chan", 32'(out_chan), 32'(exp_seq3[i]));
      check("rr_all_valid", 32'(out_valid), 32'h1);
    end

    // Round-robin over a sparse valid set, then a single channel
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) in_valid = 4'b0010;
      step();
      check("rr_sparse_chan", 32'(out_chan), 32'(exp_seq4[i]));
    end

    // Backpressure holds the beat on channel 1
    held = out_data;
    in_data = 32'h44335511;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_chan", 32'(out_chan), 32'h1);
      check("bp_data", 32'(out_data), 32'(held));
      check("bp_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_data", 32'(out_data), 32'h55);
    check("bp_release_valid", 32'(out_valid), 32'h1);

    // N=3 with sel=3: nothing is ever granted
    for (int i = 0; i < 5; i++) begin
      step();
      check("n3_in_ready", 32'(in_ready3), 32'h0);
      check("n3_out_valid", 32'(out_valid3), 32'h0);
    end

`ifdef MUX_LOCK_EN
    // Packet lock: three beats on channel 1 before channel 2 gets a turn
    do_reset();
    mode = 1'b1; in_valid = 4'b0110; in_data = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      in_last = (i < 2) ? 4'b1101 : 4'b1111;
      step();
      check("lock_chan", 32'(out_chan), (i < 3) ? 32'h1 : 32'h2);
    end
`endif

    // Randomized traffic with occasional resets and mode changes
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_LOCK_EN
      in_last   = 4'($urandom);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
